// File: rtl/uart_line_receiver.sv
// Collects uart_rx bytes into LF-terminated lines (CR stripped), flags "HELLO ALINX",
// and replays each completed line over a valid/ready byte port.
module uart_line_receiver #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,
    output logic       line_valid,
    output logic [5:0] line_len,
    output logic       line_match,
    output logic       overflow,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready
);
    localparam int         PTR_W     = $clog2(MAX_LEN);
    localparam logic [5:0] MAX_CNT   = 6'(MAX_LEN);
    localparam logic [5:0] MATCH_LEN = 6'd11;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;

    typedef enum logic {COLLECT, READOUT} state_t;

    state_t             state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic               drop_q, drop_d;
    logic               match_ok_q, match_ok_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               line_valid_q, line_valid_d;
    logic [5:0]         line_len_q, line_len_d;
    logic               line_match_q, line_match_d;
    logic               overflow_q, overflow_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_en;
    logic [7:0]         line_buf_q [MAX_LEN];

    // Reference line "HELLO ALINX", one character per payload position.
    function automatic logic [7:0] match_char(input logic [5:0] idx);
        case (idx)
            6'd0:    return 8'h48;
            6'd1:    return 8'h45;
            6'd2:    return 8'h4C;
            6'd3:    return 8'h4C;
            6'd4:    return 8'h4F;
            6'd5:    return 8'h20;
            6'd6:    return 8'h41;
            6'd7:    return 8'h4C;
            6'd8:    return 8'h49;
            6'd9:    return 8'h4E;
            6'd10:   return 8'h58;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        drop_d       = drop_q;
        match_ok_d   = match_ok_q;
        rd_ptr_d     = rd_ptr_q;
        line_valid_d = 1'b0;
        line_len_d   = line_len_q;
        line_match_d = line_match_q;
        overflow_d   = overflow_q;
        rd_valid_d   = rd_valid_q;
        wr_en        = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (rx_data_valid) begin
                    if (rx_data == CHAR_LF) begin
                        // A bare LF with nothing collected or dropped is not a line.
                        if (count_q != 6'd0 || drop_q) begin
                            line_valid_d = 1'b1;
                            line_len_d   = count_q;
                            overflow_d   = drop_q;
                            line_match_d = match_ok_q && (count_q == MATCH_LEN) && !drop_q;
                            rd_valid_d   = 1'b1;
                            rd_ptr_d     = '0;
                            state_d      = READOUT;
                            count_d      = 6'd0;
                            drop_d       = 1'b0;
                            match_ok_d   = 1'b1;
                        end
                    end else if (rx_data != CHAR_CR) begin
                        if (count_q < MAX_CNT) begin
                            wr_en      = 1'b1;
                            count_d    = count_q + 6'd1;
                            match_ok_d = match_ok_q && (count_q < MATCH_LEN)
                                         && (rx_data == match_char(count_q));
                        end else begin
                            drop_d     = 1'b1;
                            match_ok_d = 1'b0;
                        end
                    end
                end
            end
            READOUT: begin
                if (rd_valid_q && rd_ready) begin
                    if (6'(rd_ptr_q) == line_len_q - 6'd1) begin
                        rd_valid_d = 1'b0;
                        rd_ptr_d   = '0;
                        state_d    = COLLECT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            count_q      <= 6'd0;
            drop_q       <= 1'b0;
            match_ok_q   <= 1'b1;
            rd_ptr_q     <= '0;
            line_valid_q <= 1'b0;
            line_len_q   <= 6'd0;
            line_match_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            match_ok_q   <= match_ok_d;
            rd_ptr_q     <= rd_ptr_d;
            line_valid_q <= line_valid_d;
            line_len_q   <= line_len_d;
            line_match_q <= line_match_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Payload storage needs no reset; only positions below line_len are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf_q[count_q[PTR_W-1:0]] <= rx_data;
        end
    end

    assign rx_data_ready = (state_q == COLLECT);
    assign line_valid    = line_valid_q;
    assign line_len      = line_len_q;
    assign line_match    = line_match_q;
    assign overflow      = overflow_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_valid_q ? line_buf_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_line_receiver.sv
// Scoreboard bench for uart_line_receiver: line summaries and replay bytes are queued
// when lines are sent and checked by an independent monitor.
module tb_uart_line_receiver;
    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       line_valid;
    logic [5:0] line_len;
    logic       line_match;
    logic       overflow;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int len;
        bit mtch;
        bit ovf;
    } line_t;

    line_t      exp_lines[$];
    logic [7:0] exp_bytes[$];

    uart_line_receiver #(.MAX_LEN(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .line_valid   (line_valid),
        .line_len     (line_len),
        .line_match   (line_match),
        .overflow     (overflow),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every line pulse and every replay transfer against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (line_valid) begin
                if (exp_lines.size() == 0) begin
                    check("unexpected_line_valid", 1, 0);
                end else begin
                    line_t e;
                    e = exp_lines.pop_front();
                    check("line_len", int'(line_len), e.len);
                    check("line_match", int'(line_match), int'(e.mtch));
                    check("overflow", int'(overflow), int'(e.ovf));
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_replay_byte", int'(rd_data), -1);
                end else begin
                    logic [7:0] b;
                    b = exp_bytes.pop_front();
                    check("replay_byte", int'(rd_data), int'(b));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!rx_data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("rx_ready_timeout", 0, 1);
        end
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    // len==0 means no line_valid is expected.
    task automatic send_line(input string s, input int len, input bit m, input bit o,
                             input string rep);
        if (len > 0) begin
            line_t e;
            e.len = len;
            e.mtch = m;
            e.ovf = o;
            exp_lines.push_back(e);
            for (int i = 0; i < rep.len(); i++) exp_bytes.push_back(rep[i]);
        end
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Count negedges with rx_data_ready low right after a line's LF is accepted.
    task automatic ready_gap(input string name, input int exp);
        int n = 0;
        while (!rx_data_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp);
    endtask

    initial begin
        int xfers;
        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        rd_ready      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", int'(rx_data_ready), 1);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_line_valid", int'(line_valid), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Matching line, back-to-back replay: ready low for exactly line_len cycles.
        send_line("HELLO ALINX\r\n", 11, 1'b1, 1'b0, "HELLO ALINX");
        ready_gap("gap_hello", 11);

        // Near misses and a bare LF between them.
        send_line("HELLO ALINY\r\n", 11, 1'b0, 1'b0, "HELLO ALINY");
        send_line("\n", 0, 1'b0, 1'b0, "");
        repeat (3) @(negedge clk);
        check("bare_lf_stays_collect", int'(rx_data_ready), 1);
        check("bare_lf_len_held", int'(line_len), 11);
        send_line("HELLO ALINXX\n", 12, 1'b0, 1'b0, "HELLO ALINXX");

        // Overflow: 20 bytes, only the first 16 kept.
        send_line("ABCDEFGHIJKLMNOPQRST\n", 16, 1'b0, 1'b1, "ABCDEFGHIJKLMNOP");
        ready_gap("gap_overflow", 16);
        check("overflow_held", int'(overflow), 1);
        send_line("HI\n", 2, 1'b0, 1'b0, "HI");
        ready_gap("gap_hi", 2);
        check("overflow_cleared", int'(overflow), 0);

        // Backpressure: stall 5 cycles, then toggle rd_ready.
        rd_ready = 1'b0;
        send_line("ABC\n", 3, 1'b0, 1'b0, "ABC");
        for (int i = 0; i < 5; i++) begin
            check("stall_rd_valid", int'(rd_valid), 1);
            check("stall_rd_data", int'(rd_data), 8'h41);
            check("stall_rx_ready", int'(rx_data_ready), 0);
            @(negedge clk);
        end
        xfers = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 rd_ready = (c % 2 == 0);
            @(negedge clk);
            check("toggle_rx_ready", int'(rx_data_ready), int'(xfers == 3));
            if (rd_valid && rd_ready) xfers++;
        end
        check("toggle_xfers", xfers, 3);
        rd_ready = 1'b1;

        // Asynchronous reset in the middle of a replay.
        send_line("HELLO ALINX\r\n", 11, 1'b1, 1'b0, "HE");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rd_valid", int'(rd_valid), 0);
        check("midrst_rx_ready", int'(rx_data_ready), 1);
        check("midrst_line_len", int'(line_len), 0);
        check("midrst_line_match", int'(line_match), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_line("OK\n", 2, 1'b0, 1'b0, "OK");
        ready_gap("gap_ok", 2);

        repeat (3) @(negedge clk);
        check("lines_left", exp_lines.size(), 0);
        check("bytes_left", exp_bytes.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
